tgate_bus_arbiter: RTL and testbench
====================================

Name: tgate_bus_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared output node driven by N switch-level driver cells (pmos/nmos pull-up/pull-down pairs or transmission gates).
- Grants one requester at a time and enables that requester's driver only after a programmable dead time.
- Guarantees break-before-make, so two drivers never fight on the shared node.
- Sits between the requesting pipeline stages and the driver-cell enable inputs.

Parameters:
- N, 4, number of requesters/drivers (2..8).
- DEAD, 1, turnaround cycles between grant and driver enable (0..7).
- MAX_HOLD, 8, maximum consecutive driving cycles while other requests are pending; 0 means unlimited.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  per-requester access request, level-sensitive.
- gnt  output  N  one-hot grant (owner selected), registered.
- drv_en  output  N  one-hot driver enable to the driver cells, registered.
- gnt_id  output  clog2(N)  index of the current owner; 0 when idle.
- bus_busy  output  1  high whenever gnt is non-zero.

Behaviour:
- Reset:
  - rst_n low asynchronously forces gnt=0, drv_en=0, gnt_id=0, bus_busy=0, state IDLE, rr pointer ptr=0, counters 0.
  - Reset asserted mid-operation drops drv_en immediately, with no clock edge needed.
- FSM states: IDLE, TURN, OWN.
- IDLE:
  - gnt=0, drv_en=0.
  - If req non-zero at a rising edge, the winner is the first set bit searching from ptr upward, wrapping N-1 to 0.
  - The edge loads gnt=onehot(winner) and gnt_id=winner.
  - DEAD>0: go to TURN with dcnt=DEAD.
  - DEAD=0: go directly to OWN, with drv_en loaded equal to gnt on the same edge.
- TURN:
  - gnt held, drv_en=0; dcnt decrements each edge.
  - On the edge where dcnt==1: go to OWN, drv_en<=gnt, hcnt<=1.
  - If req[owner] is low at any edge in TURN: abandon. gnt<=0, ptr<=(owner+1) mod N, go to IDLE; drv_en never asserts.
- OWN:
  - drv_en==gnt. hcnt increments each edge, saturating at MAX_HOLD.
  - Release condition at an edge:
    - req[owner]==0, or
    - MAX_HOLD!=0 and hcnt==MAX_HOLD and any other req bit is set.
  - On release: gnt<=0, drv_en<=0, gnt_id<=0, ptr<=(owner+1) mod N, go to IDLE.
  - With MAX_HOLD reached and no other requester pending, the owner keeps the node and hcnt holds at MAX_HOLD.
- Break-before-make:
  - Every ownership change passes through at least one IDLE cycle with drv_en=0, then DEAD TURN cycles.
  - Minimum all-disabled gap between two drivers = 1+DEAD cycles.
- Latency:
  - req rising before edge k gives gnt visible after edge k and drv_en visible after edge k+DEAD.
  - req falling before edge j clears drv_en and gnt after edge j.
- Invariants, checked every cycle:
  - gnt and drv_en are one-hot-or-zero.
  - (drv_en & ~gnt)==0.
  - bus_busy==|gnt.
  - gnt_id matches gnt when busy.
- New requests arriving during TURN/OWN have no effect until the next IDLE arbitration.
- Requests from non-owners are never lost while held high.
- Fairness: any continuously-asserted request is granted within N-1 other ownerships.
- Arithmetic: ptr wraps modulo N. dcnt and hcnt are 3-bit and 4-bit respectively, sized for the parameter maxima.

Test Plan (N=4, DEAD=1, MAX_HOLD=8 unless stated):
- Reset check: hold rst_n=0 with req=4'b1111 and clk running -> gnt=0, drv_en=0, bus_busy=0, gnt_id=0 throughout.
- Single requester: req=4'b0100 set before edge 1 -> gnt=0100 and gnt_id=2 after edge 1; drv_en=0100 after edge 2. Clear req before edge 6 -> gnt=drv_en=0 after edge 6; next arbitration starts from ptr=3.
- All request, each releases after 3 OWN cycles: req=4'b1111 from reset -> owners in order 0,1,2,3,0. Each change shows exactly 1 IDLE cycle plus 1 TURN cycle with drv_en=0.
- Hog limit: req[0] held constantly, req[1] raised while 0 owns -> drv_en=0001 for exactly 8 cycles, then 2 disabled cycles, then drv_en=0010. With DEAD=0 and MAX_HOLD=0, req[0] keeps the node indefinitely.
- Abandon in TURN: req=4'b1000, dropped during the TURN cycle -> gnt returns to 0, drv_en stays 0000 for the whole sequence, next winner search starts at index 0.
- Async reset in OWN: while drv_en=0010, pulse rst_n low between clock edges -> drv_en, gnt and bus_busy fall immediately. After release with req=4'b0010 still high, a fresh grant to 1 follows the normal 1+DEAD latency.

Source files
------------

// File: rtl/tgate_bus_arbiter_if.sv
// Request/grant/enable bundle between requesting stages, the arbiter and the driver cells.
interface tgate_bus_arbiter_if #(
    parameter int N = 4
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   drv_en;
    logic [IDW-1:0] gnt_id;
    logic           bus_busy;

    modport master (output req, input gnt, input drv_en, input gnt_id, input bus_busy);
    modport slave  (input req, output gnt, output drv_en, output gnt_id, output bus_busy);
endinterface

// File: rtl/tgate_bus_arbiter.sv
// Round-robin owner selection for a shared node with a dead-time gap between
// grant and driver enable, so no two driver cells ever conduct together.
module tgate_bus_arbiter #(
    parameter int N        = 4,
    parameter int DEAD     = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    tgate_bus_arbiter_if.slave bus
);
    localparam int             IDW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [N-1:0]   ONE      = N'(1);
    localparam logic [2:0]     DEAD_C   = 3'(DEAD);
    localparam logic [3:0]     HOLD_C   = 4'(MAX_HOLD);
    localparam logic [3:0]     HOLD_LIM = (MAX_HOLD == 0) ? 4'd15 : HOLD_C;

    typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [N-1:0]   drv_q, drv_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [2:0]     dcnt_q, dcnt_d;
    logic [3:0]     hcnt_q, hcnt_d;

    logic           owner_req;
    logic           others_req;
    logic [IDW-1:0] win;
    logic [IDW-1:0] nxt_ptr;

    // First set request at or above p, wrapping from N-1 back to 0.
    function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic [IDW-1:0] w;
        logic           found;
        int             idx;
        w     = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(p) + i) % N;
            if (!found && r[idx]) begin
                w     = IDW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] v);
        if (int'(v) >= N - 1) return '0;
        return v + IDW'(1);
    endfunction

    assign owner_req  = |(bus.req & gnt_q);
    assign others_req = |(bus.req & ~gnt_q);
    assign win        = rr_pick(bus.req, ptr_q);
    assign nxt_ptr    = wrap_inc(id_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            drv_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            dcnt_q  <= '0;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            drv_q   <= drv_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            dcnt_q  <= dcnt_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        drv_d   = drv_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        dcnt_d  = dcnt_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                drv_d = '0;
                id_d  = '0;
                if (|bus.req) begin
                    gnt_d = ONE << win;
                    id_d  = win;
                    if (DEAD == 0) begin
                        state_d = OWN;
                        drv_d   = ONE << win;
                        hcnt_d  = 4'd1;
                    end else begin
                        state_d = TURN;
                        dcnt_d  = DEAD_C;
                    end
                end
            end
            TURN: begin
                drv_d = '0;
                // Owner gave up before its driver was ever enabled.
                if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    ptr_d   = nxt_ptr;
                    dcnt_d  = '0;
                end else if (dcnt_q <= 3'd1) begin
                    state_d = OWN;
                    drv_d   = gnt_q;
                    dcnt_d  = '0;
                    hcnt_d  = 4'd1;
                end else begin
                    dcnt_d = dcnt_q - 3'd1;
                end
            end
            OWN: begin
                drv_d = gnt_q;
                if (!owner_req || (MAX_HOLD != 0 && hcnt_q == HOLD_C && others_req)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    drv_d   = '0;
                    id_d    = '0;
                    ptr_d   = nxt_ptr;
                    hcnt_d  = '0;
                end else if (hcnt_q != HOLD_LIM) begin
                    hcnt_d = hcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                drv_d   = '0;
                id_d    = '0;
            end
        endcase
    end

    always_comb begin
        bus.gnt      = gnt_q;
        bus.drv_en   = drv_q;
        bus.gnt_id   = id_q;
        bus.bus_busy = |gnt_q;
    end
endmodule

// File: tb/tb_tgate_bus_arbiter.sv
// Directed bench for tgate_bus_arbiter: a vector table plus hand-written multi-cycle sequences.
module tb_tgate_bus_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tgate_bus_arbiter_if #(.N(4)) bif ();
    tgate_bus_arbiter_if #(.N(4)) bif0 ();

    tgate_bus_arbiter #(.N(4), .DEAD(1), .MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    tgate_bus_arbiter #(.N(4), .DEAD(0), .MAX_HOLD(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif0)
    );

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [3:0] drv;
        logic [1:0] id;
        logic       busy;
    } vec_t;

    vec_t vt[24];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic inv_ok(input logic [3:0] g, input logic [3:0] d,
                                    input logic [1:0] id, input logic busy);
        logic ok;
        ok = ($countones(g) <= 1) && ($countones(d) <= 1);
        ok = ok && ((d & ~g) == 4'b0000);
        ok = ok && (busy == (|g));
        if (|g) ok = ok && (g == (4'b0001 << id));
        return ok;
    endfunction

    always @(negedge clk) begin
        chk("invariant_dut", 32'(inv_ok(bif.gnt, bif.drv_en, bif.gnt_id, bif.bus_busy)), 32'd1);
        chk("invariant_dut0", 32'(inv_ok(bif0.gnt, bif0.drv_en, bif0.gnt_id, bif0.bus_busy)), 32'd1);
    end

    initial begin
        int own[5];
        int cnt;
        checks   = 0;
        failures = 0;
        own      = '{0, 1, 2, 3, 0};

        // req before edge, then gnt/drv/id/busy expected after that edge
        vt[0]  = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b1};
        vt[1]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vt[2]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vt[3]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vt[4]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1};
        vt[5]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[6]  = '{4'b1001, 4'b1000, 4'b0000, 2'd3, 1'b1};
        vt[7]  = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vt[8]  = '{4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[9]  = '{4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1};
        vt[10] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1};
        vt[11] = '{4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1};
        vt[12] = '{4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[13] = '{4'b0010, 4'b0010, 4'b0000, 2'd1, 1'b1};
        vt[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[15] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[16] = '{4'b1000, 4'b1000, 4'b0000, 2'd3, 1'b1};
        vt[17] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[18] = '{4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b1};
        vt[19] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[20] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
        vt[21] = '{4'b1001, 4'b1000, 4'b0000, 2'd3, 1'b1};
        vt[22] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1};
        vt[23] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

        rst_n    = 1'b0;
        bif.req  = 4'b1111;
        bif0.req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_gnt", 32'(bif.gnt), 32'd0);
            chk("rst_drv", 32'(bif.drv_en), 32'd0);
            chk("rst_busy", 32'(bif.bus_busy), 32'd0);
            chk("rst_id", 32'(bif.gnt_id), 32'd0);
            chk("rst_drv0", 32'(bif0.drv_en), 32'd0);
        end
        bif0.req = 4'b0000;
        rst_n    = 1'b1;

        for (int i = 0; i < 24; i++) begin
            bif.req = vt[i].req;
            step();
            chk($sformatf("vec%0d_gnt", i), 32'(bif.gnt), 32'(vt[i].gnt));
            chk($sformatf("vec%0d_drv", i), 32'(bif.drv_en), 32'(vt[i].drv));
            chk($sformatf("vec%0d_id", i), 32'(bif.gnt_id), 32'(vt[i].id));
            chk($sformatf("vec%0d_busy", i), 32'(bif.bus_busy), 32'(vt[i].busy));
        end

        // Rotation with everyone requesting; each owner drops after 3 driving cycles.
        bif.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rot_turn_gnt", 32'(bif.gnt), 32'(4'b0001 << own[k]));
            chk("rot_turn_drv", 32'(bif.drv_en), 32'd0);
            for (int c = 0; c < 3; c++) begin
                step();
                chk("rot_own_drv", 32'(bif.drv_en), 32'(4'b0001 << own[k]));
            end
            bif.req = 4'b1111 & ~(4'b0001 << own[k]);
            step();
            chk("rot_idle_gnt", 32'(bif.gnt), 32'd0);
            chk("rot_idle_drv", 32'(bif.drv_en), 32'd0);
            bif.req = (k == 4) ? 4'b0000 : 4'b1111;
        end
        step();
        chk("rot_end_busy", 32'(bif.bus_busy), 32'd0);

        // Hog limit: requester 0 stays high, requester 1 joins once 0 drives.
        bif.req = 4'b0001;
        step();
        chk("hog_turn_gnt", 32'(bif.gnt), 32'b0001);
        step();
        chk("hog_first_drv", 32'(bif.drv_en), 32'b0001);
        bif.req = 4'b0011;
        cnt = 1;
        for (int b = 0; b < 20; b++) begin
            step();
            if (bif.drv_en != 4'b0001) break;
            cnt++;
        end
        chk("hog_drive_cycles", 32'(cnt), 32'd8);
        chk("hog_gap1_gnt", 32'(bif.gnt), 32'd0);
        chk("hog_gap1_drv", 32'(bif.drv_en), 32'd0);
        step();
        chk("hog_gap2_gnt", 32'(bif.gnt), 32'b0010);
        chk("hog_gap2_drv", 32'(bif.drv_en), 32'd0);
        step();
        chk("hog_next_drv", 32'(bif.drv_en), 32'b0010);

        // Asynchronous reset while requester 1 drives.
        bif.req = 4'b0010;
        step();
        chk("ar_pre_drv", 32'(bif.drv_en), 32'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_drv", 32'(bif.drv_en), 32'd0);
        chk("ar_gnt", 32'(bif.gnt), 32'd0);
        chk("ar_busy", 32'(bif.bus_busy), 32'd0);
        #2 rst_n = 1'b1;
        step();
        chk("ar_regrant_gnt", 32'(bif.gnt), 32'b0010);
        chk("ar_regrant_id", 32'(bif.gnt_id), 32'd1);
        chk("ar_regrant_drv", 32'(bif.drv_en), 32'd0);
        step();
        chk("ar_regrant_drv2", 32'(bif.drv_en), 32'b0010);
        bif.req = 4'b0000;

        // No dead time and no hold limit: requester 0 keeps the node.
        bif0.req = 4'b0011;
        step();
        chk("nd_gnt", 32'(bif0.gnt), 32'b0001);
        chk("nd_drv", 32'(bif0.drv_en), 32'b0001);
        for (int c = 0; c < 20; c++) begin
            step();
            chk("nd_hold_drv", 32'(bif0.drv_en), 32'b0001);
        end
        bif0.req = 4'b0010;
        step();
        chk("nd_rel_gnt", 32'(bif0.gnt), 32'd0);
        step();
        chk("nd_next_gnt", 32'(bif0.gnt), 32'b0010);
        chk("nd_next_drv", 32'(bif0.drv_en), 32'b0010);
        chk("nd_next_id", 32'(bif0.gnt_id), 32'd1);
        bif0.req = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
